mmio_bus_ctrl: RTL and testbench

- Parametrised memory-mapped bus controller between the rv32 core's data port and NSLV peripherals (data memory, keyboard buffer, VGA memory, ...).
- Decodes read and write addresses by upper-address tag and gates per-slave write enables.
- Pipelines read-select so read data aligns with slaves' one-cycle synchronous read latency.
- Records unmapped accesses in sticky error registers with a saturating counter.

---
 rtl/bus_pkg.sv | 18 +
 rtl/addr_decode.sv | 36 +++
 rtl/mmio_bus_ctrl.sv | 125 ++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the rv32 memory-mapped bus: data width, default tag
// width, the standard region tags and a helper that extracts an address tag.
package bus_pkg;

  localparam int DATA_W        = 32;
  localparam int TAG_W_DEFAULT = 12;

  localparam logic [TAG_W_DEFAULT-1:0] TAG_DMEM = 12'h001;
  localparam logic [TAG_W_DEFAULT-1:0] TAG_VGA  = 12'h002;
  localparam logic [TAG_W_DEFAULT-1:0] TAG_KBD  = 12'h003;

  // Upper tag_w bits of addr, right-justified and zero-extended.
  function automatic logic [DATA_W-1:0] tag_of(input logic [DATA_W-1:0] addr,
                                               input int tag_w);
    return addr >> (DATA_W - tag_w);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational region decoder: compares the address tag against each slave's
// tag and produces a one-hot hit vector (lowest index wins) plus a miss flag.
module addr_decode
  import bus_pkg::*;
#(
  parameter int                     NSLV        = 3,
  parameter int                     TAG_W       = TAG_W_DEFAULT,
  parameter logic [NSLV*TAG_W-1:0]  REGION_TAGS = {TAG_VGA, TAG_KBD, TAG_DMEM}
) (
  input  logic              en,
  input  logic [DATA_W-1:0] addr,
  output logic [NSLV-1:0]   hit,
  output logic              miss
);

  logic [DATA_W-1:0] addr_tag;
  logic              found;

  // First matching region claims the access so duplicate tags stay one-hot.
  always_comb begin
    addr_tag = tag_of(addr, TAG_W);
    hit      = '0;
    found    = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!found && addr_tag == DATA_W'(REGION_TAGS[i*TAG_W +: TAG_W])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!en) begin
      hit = '0;
    end
    miss = en & ~found;
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller between the core data port and NSLV slaves:
// address decode, one-cycle read return alignment and sticky error capture.
module mmio_bus_ctrl
  import bus_pkg::*;
#(
  parameter int                     NSLV         = 3,
  parameter int                     TAG_W        = TAG_W_DEFAULT,
  parameter logic [NSLV*TAG_W-1:0]  REGION_TAGS  = {TAG_VGA, TAG_KBD, TAG_DMEM},
  parameter logic [DATA_W-1:0]      DEFAULT_DATA = 32'h0000_0000,
  parameter int                     CNT_W        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [DATA_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_addr,
  output logic [NSLV-1:0]        slv_rd_sel,
  output logic [NSLV-1:0]        slv_we,
  input  logic [NSLV*DATA_W-1:0] slv_rdata,
  output logic                   err_flag,
  output logic [DATA_W-1:0]      err_addr,
  output logic                   err_is_wr,
  output logic [CNT_W-1:0]       err_count,
  input  logic                   err_clr
);

  localparam logic [CNT_W+1:0] CNT_MAX = (CNT_W+2)'({CNT_W{1'b1}});

  logic              rd_miss;
  logic              wr_miss;
  logic [NSLV-1:0]   sel_q;
  logic              miss_q;
  logic              valid_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mux_data;

  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W+1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_next;
  logic              flag_next;
  logic [DATA_W-1:0] addr_next;
  logic              is_wr_next;

  addr_decode #(
    .NSLV        (NSLV),
    .TAG_W       (TAG_W),
    .REGION_TAGS (REGION_TAGS)
  ) u_rd_decode (
    .en   (rd_en),
    .addr (rd_addr),
    .hit  (slv_rd_sel),
    .miss (rd_miss)
  );

  addr_decode #(
    .NSLV        (NSLV),
    .TAG_W       (TAG_W),
    .REGION_TAGS (REGION_TAGS)
  ) u_wr_decode (
    .en   (wr_en),
    .addr (wr_addr),
    .hit  (slv_we),
    .miss (wr_miss)
  );

  // Return mux works off the select captured with the request, matching the
  // slaves' one-cycle synchronous read latency.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        mux_data = mux_data | slv_rdata[i*DATA_W +: DATA_W];
      end
    end
    if (miss_q) begin
      mux_data = DEFAULT_DATA;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = valid_q ? mux_data : hold_q;

  // A clear in the same cycle as a new miss restarts the record from that miss.
  always_comb begin
    cnt_base   = err_clr ? '0 : err_count;
    cnt_sum    = (CNT_W+2)'(cnt_base) + (CNT_W+2)'(rd_miss) + (CNT_W+2)'(wr_miss);
    cnt_next   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    flag_next  = err_flag & ~err_clr;
    addr_next  = err_clr ? '0 : err_addr;
    is_wr_next = err_is_wr & ~err_clr;
    if ((!err_flag || err_clr) && (rd_miss || wr_miss)) begin
      flag_next  = 1'b1;
      addr_next  = rd_miss ? rd_addr : wr_addr;
      is_wr_next = ~rd_miss;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q     <= '0;
      miss_q    <= 1'b0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
      err_is_wr <= 1'b0;
      err_count <= '0;
    end else begin
      sel_q     <= slv_rd_sel;
      miss_q    <= rd_miss;
      valid_q   <= rd_en;
      if (valid_q) begin
        hold_q <= mux_data;
      end
      err_flag  <= flag_next;
      err_addr  <= addr_next;
      err_is_wr <= is_wr_next;
      err_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed self-checking bench for mmio_bus_ctrl with default parameters
// (slave 0 tag 0x001, slave 1 tag 0x003, slave 2 tag 0x002).
module tb_mmio_bus_ctrl;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [2:0]  slv_rd_sel;
  logic [2:0]  slv_we;
  logic [95:0] slv_rdata;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_is_wr;
  logic [7:0]  err_count;
  logic        err_clr;

  int vectors;
  int miscompares;

  mmio_bus_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .slv_rd_sel (slv_rd_sel),
    .slv_we     (slv_we),
    .slv_rdata  (slv_rdata),
    .err_flag   (err_flag),
    .err_addr   (err_addr),
    .err_is_wr  (err_is_wr),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic re, input logic [31:0] ra,
                               input logic we, input logic [31:0] wa,
                               input logic clr);
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    err_clr = clr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    slv_rdata   = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    checkOutput("rst_err_flag", 32'(err_flag), 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'h0);
    checkOutput("rst_err_is_wr", 32'(err_is_wr), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    $display("[TB] single read to slave 0");
    applyStimulus(1'b1, 32'h0010_0004, 1'b0, 32'h0, 1'b0);
    checkOutput("rd1_sel", 32'(slv_rd_sel), 32'b001);
    checkOutput("rd1_idle_valid", 32'(rd_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rd1_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd1_data", rd_data, 32'hDEAD_BEEF);
    checkOutput("rd1_sel_off", 32'(slv_rd_sel), 32'b000);
    tick();
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h5555_5555};
    #1;
    checkOutput("rd1_hold_valid", 32'(rd_valid), 32'd0);
    checkOutput("rd1_hold_data", rd_data, 32'hDEAD_BEEF);
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};

    $display("[TB] mapped write to slave 1");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0030_0000, 1'b0);
    checkOutput("wr1_we", 32'(slv_we), 32'b010);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("wr1_we_off", 32'(slv_we), 32'b000);
    checkOutput("wr1_err_flag", 32'(err_flag), 32'd0);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 32'h0010_0000, 1'b0, 32'h0, 1'b0);
    checkOutput("b2b_sel0", 32'(slv_rd_sel), 32'b001);
    tick();
    applyStimulus(1'b1, 32'h0030_0000, 1'b0, 32'h0, 1'b0);
    checkOutput("b2b_valid0", 32'(rd_valid), 32'd1);
    checkOutput("b2b_data0", rd_data, 32'hDEAD_BEEF);
    checkOutput("b2b_sel1", 32'(slv_rd_sel), 32'b010);
    tick();
    applyStimulus(1'b1, 32'h0020_0000, 1'b0, 32'h0, 1'b0);
    checkOutput("b2b_valid1", 32'(rd_valid), 32'd1);
    checkOutput("b2b_data1", rd_data, 32'h2222_2222);
    checkOutput("b2b_sel2", 32'(slv_rd_sel), 32'b100);
    tick();
    applyStimulus(1'b1, 32'h0020_0008, 1'b1, 32'h0020_0010, 1'b0);
    checkOutput("b2b_valid2", 32'(rd_valid), 32'd1);
    checkOutput("b2b_data2", rd_data, 32'h3333_3333);
    checkOutput("rw_same_sel", 32'(slv_rd_sel), 32'b100);
    checkOutput("rw_same_we", 32'(slv_we), 32'b100);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rw_same_data", rd_data, 32'h3333_3333);
    checkOutput("rw_same_err", 32'(err_flag), 32'd0);

    $display("[TB] unmapped read and write together");
    applyStimulus(1'b1, 32'h0050_0000, 1'b1, 32'h0060_0000, 1'b0);
    checkOutput("miss_sel", 32'(slv_rd_sel), 32'b000);
    checkOutput("miss_we", 32'(slv_we), 32'b000);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("miss_valid", 32'(rd_valid), 32'd1);
    checkOutput("miss_data", rd_data, 32'h0);
    checkOutput("miss_flag", 32'(err_flag), 32'd1);
    checkOutput("miss_addr", err_addr, 32'h0050_0000);
    checkOutput("miss_is_wr", 32'(err_is_wr), 32'd0);
    checkOutput("miss_count", 32'(err_count), 32'd2);

    $display("[TB] later error keeps first address");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0070_0000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("later_addr", err_addr, 32'h0050_0000);
    checkOutput("later_is_wr", 32'(err_is_wr), 32'd0);
    checkOutput("later_count", 32'(err_count), 32'd3);

    $display("[TB] clear with simultaneous new error");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0080_0000, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("clrnew_flag", 32'(err_flag), 32'd1);
    checkOutput("clrnew_addr", err_addr, 32'h0080_0000);
    checkOutput("clrnew_is_wr", 32'(err_is_wr), 32'd1);
    checkOutput("clrnew_count", 32'(err_count), 32'd1);

    $display("[TB] counter saturation");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0090_0000, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("sat_count", 32'(err_count), 32'd255);
    checkOutput("sat_addr", err_addr, 32'h0080_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("clr_flag", 32'(err_flag), 32'd0);
    checkOutput("clr_addr", err_addr, 32'h0);
    checkOutput("clr_is_wr", 32'(err_is_wr), 32'd0);
    checkOutput("clr_count", 32'(err_count), 32'd0);

    $display("[TB] reset with read in flight");
    applyStimulus(1'b1, 32'h0030_0000, 1'b1, 32'h00A0_0000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("flight_pre_data", rd_data, 32'h2222_2222);
    checkOutput("flight_pre_flag", 32'(err_flag), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("flight_valid", 32'(rd_valid), 32'd0);
    checkOutput("flight_data", rd_data, 32'h0);
    checkOutput("flight_flag", 32'(err_flag), 32'd0);
    checkOutput("flight_addr", err_addr, 32'h0);
    checkOutput("flight_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_valid", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
